mul_unit: RTL and testbench
===========================

# mul_unit

Multi-cycle integer multiplier sitting beside the execute stage. The execute stage treats MUL-class opcodes as non-writing; this block accepts those operations and iterates a radix-2 shift-add over 32 cycles. It then returns the product to the register file and pulses `mul_release` with `flags_back_in`, which execute ORs into its NZCV register.

## Interface
- `WIDTH`, 32, operand/result width; the spec below is written for 32.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  issue strobe; sampled only in IDLE.
- `mul_type`  in  2  operation type: 00 MULI, 01 MULR, 10 MULSI, 11 MULSR. Bit1 means set flags; bit0 means register operand B.
- `destReg`  in  4  destination register, captured at start.
- `readDataFirst`  in  WIDTH  operand A, captured at start.
- `readDataSec`  in  WIDTH  operand B when `mul_type[0]`=1.
- `imm`  in  16  immediate operand B when `mul_type[0]`=0, sign-extended.
- `busy`  out  1  high from the cycle after accept through DONE.
- `writeToReg`  out  1  one-cycle write-back strobe.
- `writeReg`  out  4  write-back register index.
- `writeData`  out  WIDTH  low 32 bits of the product.
- `mul_release`  out  1  one-cycle completion pulse, coincident with `writeToReg`.
- `flags_back_in`  out  4  NZCV contribution; valid while `mul_release`=1, otherwise 0.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE, with `start`=1: latch A, B, `destReg` and `mul_type`, then go to RUN.
  - B is `readDataSec` or the sign-extended `imm`, selected by `mul_type[0]`.
  - Latch `sign` = A[31]^B[31].
  - Latch `|A|` and `|B|` as 32-bit unsigned values; |0x80000000| = 0x80000000.
  - Clear the 64-bit accumulator and set the counter to 0.
- RUN, each cycle:
  - If multiplier bit 0 is 1, add the multiplicand (shifted by the counter) into the accumulator.
  - Shift the multiplier right by 1 and increment the counter.
  - After the counter reaches 31, go to DONE.
- DONE:
  - Form P = sign ? −acc : acc, in 64-bit two's complement.
  - Drive `writeData`=P[31:0], `writeReg`=latched dest, `writeToReg`=1 and `mul_release`=1.
  - Next state is IDLE.
- Flags:
  - If latched `mul_type[1]`=0, `flags_back_in`=0000.
  - Otherwise N=P[31], Z=(P[31:0]==0), C=0, and V=1 iff P[63:32] is not all copies of P[31] (signed overflow).
- Products are always computed as signed. For MULI/MULR this changes nothing in the low 32 bits.
- `start` while `busy`=1 is ignored: no queueing, no error. The issuer stalls on `busy`.
- `start` in DONE is ignored. A new op may be accepted in the IDLE cycle that follows DONE.
- Operand inputs are don't-care except in the accept cycle.

## Timing
- Accept at edge 0 (IDLE, `start`=1).
- RUN covers edges 1–32. DONE outputs are valid during the cycle after edge 32 and sampled at edge 33.
- Issue-to-writeback latency is 33 cycles. Throughput is one op per 34 cycles.
- `writeToReg`, `writeData`, `writeReg`, `mul_release` and `flags_back_in` are registered (driven from DONE-state registers). They are zero/0000 outside DONE.
- Reset values: state IDLE; `busy`, `writeToReg`, `mul_release` = 0; `writeData` = 0; `writeReg` = 0; `flags_back_in` = 0000; counter and accumulator 0.
- Reset asserted mid-RUN or in DONE:
  - Abort immediately; no write-back or release is emitted.
  - After deassert, the block is in IDLE and the first `start` is accepted.

## Structure
- Package `mul_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - `mul_type` localparams (MULI, MULR, MULSI, MULSR);
  - flag bit indices N=3, Z=2, C=1, V=0, shared with execute.
- Sub-module `mul_shift_add_core` holds the accumulator, shift registers and counter, with a `load`/`step` interface and a `last` output.
- The top level holds the FSM, operand select, sign handling and flag generation.

## Test plan
- MULR, A=7, B=6 → at edge 33 `writeData`=42, `writeToReg`=1 for exactly one cycle, `flags_back_in`=0000.
- MULSR, A=−3 (0xFFFFFFFD), B=5 → `writeData`=0xFFFFFFF1, `flags_back_in`=1000.
- MULSI, A=0, imm=0x1234 → `writeData`=0, `flags_back_in`=0100.
- MULSR, A=B=0x00010000 → `writeData`=0, `flags_back_in`=0101 (Z, V).
- MULI, A=3, imm=0xFFFF → `writeData`=0xFFFFFFFD, `flags_back_in`=0000.
- Back-to-back and reset cases:
  - A second `start` at edge 5 is ignored, and the result matches the first op.
  - `rst` at edge 10 → no `mul_release`, `busy`=0.
  - A `start` right after reset → correct result 33 cycles later.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM states, operation codes and NZCV bit positions for the multiplier
package mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] MULI  = 2'b00;
    localparam logic [1:0] MULR  = 2'b01;
    localparam logic [1:0] MULSI = 2'b10;
    localparam logic [1:0] MULSR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic sets_flags(input logic [1:0] t);
        return t == MULSI || t == MULSR;
    endfunction

    function automatic logic reg_operand(input logic [1:0] t);
        return t == MULR || t == MULSR;
    endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// mul_shift_add_core: unsigned radix-2 shift-add datapath, one multiplier bit per step
module mul_shift_add_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic [2*WIDTH-1:0]   acc_nxt,
    output logic                 last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q, mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;

    assign last = cnt_q == CW'(WIDTH - 1);

    // accumulator value after this step; exposed so the top can finish on the last step
    always_comb begin
        acc_nxt = mplier_q[0] ? acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : acc_q;
    end

    // operand capture on load, then one shift-add iteration per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= mcand;
            mplier_q <= mplier;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step) begin
            acc_q    <= acc_nxt;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mul_unit.sv
// mul_unit: multi-cycle signed multiplier with register write-back and NZCV release
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mul_type,
    input  logic [3:0]       destReg,
    input  logic [WIDTH-1:0] readDataFirst,
    input  logic [WIDTH-1:0] readDataSec,
    input  logic [15:0]      imm,
    output logic             busy,
    output logic             writeToReg,
    output logic [3:0]       writeReg,
    output logic [WIDTH-1:0] writeData,
    output logic             mul_release,
    output logic [3:0]       flags_back_in
);

    state_e             state_q, state_d;
    logic [1:0]         type_q;
    logic [3:0]         dest_q, wreg_q, flags_q, flags_d;
    logic               sign_q, wr_q, accept, last, fin;
    logic [WIDTH-1:0]   op_b, abs_a, abs_b, wdata_q;
    logic [2*WIDTH-1:0] acc_nxt, prod;

    assign accept = state_q == S_IDLE && start;
    assign fin    = state_q == S_RUN && last;
    assign op_b   = reg_operand(mul_type) ? readDataSec : {{(WIDTH-16){imm[15]}}, imm};
    // negating the most negative value wraps to itself, which is exactly its magnitude unsigned
    assign abs_a  = readDataFirst[WIDTH-1] ? -readDataFirst : readDataFirst;
    assign abs_b  = op_b[WIDTH-1] ? -op_b : op_b;
    assign prod   = sign_q ? -acc_nxt : acc_nxt;

    assign busy          = state_q != S_IDLE;
    assign writeToReg    = wr_q;
    assign mul_release   = wr_q;
    assign writeReg      = wreg_q;
    assign writeData     = wdata_q;
    assign flags_back_in = flags_q;

    mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (state_q == S_RUN),
        .mcand  (abs_a),
        .mplier (abs_b),
        .acc_nxt(acc_nxt),
        .last   (last)
    );

    // IDLE -> RUN on accept, RUN -> DONE after the final step, DONE always returns to IDLE
    always_comb begin
        state_d = state_q == S_IDLE ? (start ? S_RUN : S_IDLE) :
                  state_q == S_RUN  ? (last ? S_DONE : S_RUN) : S_IDLE;
    end

    // NZCV from the signed product; V flags a product that does not fit WIDTH bits signed
    always_comb begin
        flags_d = '0;
        if (sets_flags(type_q)) begin
            flags_d[FLAG_N] = prod[WIDTH-1];
            flags_d[FLAG_Z] = prod[WIDTH-1:0] == '0;
            flags_d[FLAG_C] = 1'b0;
            flags_d[FLAG_V] = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
        end
    end

    // state, operation context, and DONE-cycle result registers (zero outside DONE)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            dest_q  <= '0;
            sign_q  <= 1'b0;
            wr_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                type_q <= mul_type;
                dest_q <= destReg;
                sign_q <= readDataFirst[WIDTH-1] ^ op_b[WIDTH-1];
            end
            wr_q    <= fin;
            wreg_q  <= fin ? dest_q : '0;
            wdata_q <= fin ? prod[WIDTH-1:0] : '0;
            flags_q <= fin ? flags_d : '0;
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed vectors plus a cycle-by-cycle arithmetic reference model for mul_unit
module tb_mul_unit;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [1:0]  mul_type = '0;
    logic [3:0]  destReg = '0;
    logic [31:0] rdf = '0, rds = '0;
    logic [15:0] imm = '0;
    logic        busy, writeToReg, mul_release;
    logic [3:0]  writeReg, flags_back_in;
    logic [31:0] writeData;

    int checks = 0, failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mul_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .mul_type(mul_type), .destReg(destReg),
        .readDataFirst(rdf), .readDataSec(rds), .imm(imm), .busy(busy),
        .writeToReg(writeToReg), .writeReg(writeReg), .writeData(writeData),
        .mul_release(mul_release), .flags_back_in(flags_back_in)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] opb(input logic [1:0] t, input logic [31:0] b, input logic [15:0] im);
        return t[0] ? b : 32'(signed'(im));
    endfunction

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        return 64'(longint'(signed'(a)) * longint'(signed'(b)));
    endfunction

    function automatic logic [3:0] ref_flags(input logic [63:0] p, input logic setf);
        longint sp = signed'(p);
        longint lo = longint'(signed'(p[31:0]));
        if (!setf) return 4'b0000;
        return {p[31], p[31:0] == 32'd0, 1'b0, sp != lo};
    endfunction

    // reference: phase counts edges since accept; the result is visible in phase 33
    int          m_phase = 0;
    logic [63:0] m_p = '0;
    logic        m_setf = 1'b0;
    logic [3:0]  m_reg = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) m_phase <= 0;
        else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_p     <= ref_prod(rdf, opb(mul_type, rds, imm));
                m_setf  <= mul_type[1];
                m_reg   <= destReg;
            end
        end else m_phase <= (m_phase == 33) ? 0 : m_phase + 1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", busy, m_phase != 0);
            chk("cyc_wtr", writeToReg, m_phase == 33);
            chk("cyc_rel", mul_release, m_phase == 33);
            chk("cyc_data", writeData, m_phase == 33 ? m_p[31:0] : 32'd0);
            chk("cyc_reg", writeReg, m_phase == 33 ? m_reg : 4'd0);
            chk("cyc_flags", flags_back_in, m_phase == 33 ? ref_flags(m_p, m_setf) : 4'd0);
        end
    end

    task automatic scramble();
        mul_type = 2'($urandom);
        destReg  = 4'($urandom);
        rdf      = $urandom;
        rds      = $urandom;
        imm      = 16'($urandom);
    endtask

    task automatic issue(input logic [1:0] t, input logic [3:0] d, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] im);
        @(negedge clk);
        mul_type = t; destReg = d; rdf = a; rds = b; imm = im; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        scramble();
    endtask

    task automatic wait_check(input string nm, input int k0, input logic [31:0] ed,
                              input logic [3:0] ef, input logic [3:0] er);
        int k = k0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (writeToReg) break;
        end
        chk({nm, "_lat"}, k, 33);
        chk({nm, "_data"}, writeData, ed);
        chk({nm, "_flags"}, flags_back_in, ef);
        chk({nm, "_reg"}, writeReg, er);
        chk({nm, "_rel"}, mul_release, 1'b1);
        @(negedge clk);
        chk({nm, "_pulse"}, writeToReg, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel_cnt;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wtr", writeToReg, 1'b0);
        chk("rst_rel", mul_release, 1'b0);
        chk("rst_data", writeData, 32'd0);
        chk("rst_reg", writeReg, 4'd0);
        chk("rst_flags", flags_back_in, 4'd0);
        #1 rst = 1'b0;
        cmp_en = 1'b1;

        issue(2'b01, 4'd3, 32'd7, 32'd6, 16'd0);
        wait_check("mulr_7x6", 0, 32'd42, 4'b0000, 4'd3);
        issue(2'b11, 4'd5, 32'hFFFF_FFFD, 32'd5, 16'd0);
        wait_check("mulsr_neg", 0, 32'hFFFF_FFF1, 4'b1000, 4'd5);
        issue(2'b10, 4'd1, 32'd0, 32'hDEAD_BEEF, 16'h1234);
        wait_check("mulsi_zero", 0, 32'd0, 4'b0100, 4'd1);
        issue(2'b11, 4'd15, 32'h0001_0000, 32'h0001_0000, 16'd0);
        wait_check("mulsr_ovf", 0, 32'd0, 4'b0101, 4'd15);
        issue(2'b00, 4'd2, 32'd3, 32'd9, 16'hFFFF);
        wait_check("muli_neg", 0, 32'hFFFF_FFFD, 4'b0000, 4'd2);
        issue(2'b11, 4'd7, 32'h8000_0000, 32'h8000_0000, 16'd0);
        wait_check("mulsr_minmin", 0, 32'd0, 4'b0101, 4'd7);
        issue(2'b11, 4'd8, 32'h8000_0000, 32'd1, 16'd0);
        wait_check("mulsr_min1", 0, 32'h8000_0000, 4'b1000, 4'd8);
        issue(2'b10, 4'd9, 32'hFFFF_FFFF, 32'd0, 16'h8000);
        wait_check("mulsi_m1", 0, 32'h0000_8000, 4'b0000, 4'd9);
        issue(2'b11, 4'd10, 32'h7FFF_FFFF, 32'd2, 16'd0);
        wait_check("mulsr_maxx2", 0, 32'hFFFF_FFFE, 4'b1001, 4'd10);

        issue(2'b01, 4'd4, 32'd11, 32'd13, 16'd0);
        repeat (5) @(negedge clk);
        mul_type = 2'b11; destReg = 4'd12; rdf = 32'd100; rds = 32'd100; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("ignore_busy", busy, 1'b1);
        wait_check("ignore_start", 5, 32'd143, 4'b0000, 4'd4);

        @(negedge clk);
        mul_type = 2'b01; destReg = 4'd6; rdf = 32'd9; rds = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 mul_type = 2'b11; destReg = 4'd11; rdf = 32'hFFFF_FFFE; rds = 32'd4;
        wait_check("held_first", 0, 32'd81, 4'b0000, 4'd6);
        @(posedge clk);
        #1 start = 1'b0;
        scramble();
        wait_check("held_second", 0, 32'hFFFF_FFF8, 4'b1000, 4'd11);

        issue(2'b11, 4'd13, 32'd1000, 32'd1000, 16'd0);
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("abort_busy", busy, 1'b0);
        chk("abort_wtr", writeToReg, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        rel_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (mul_release) rel_cnt++;
        end
        chk("abort_no_release", rel_cnt, 0);

        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        issue(2'b11, 4'd14, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 16'd0);
        wait_check("after_rst", 0, 32'd42, 4'b0000, 4'd14);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
